// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - state and mode encodings shared by the countdown timer
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - phase counter producing half-unit and unit ticks
module timer_prescaler #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_half_tick,
  output logic o_unit_tick
);

  localparam int PH_W = $clog2(CLK_HZ);
  localparam logic [PH_W-1:0] HALF_LAST = PH_W'(CLK_HZ / 2 - 1);
  localparam logic [PH_W-1:0] UNIT_LAST = PH_W'(CLK_HZ - 1);

  logic [PH_W-1:0] r_phase;

  // Ticks are qualified by enable so a frozen phase never strobes.
  assign o_half_tick = i_enable && (r_phase == HALF_LAST);
  assign o_unit_tick = i_enable && (r_phase == UNIT_LAST);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_phase <= '0;
    end else if (i_clear || o_unit_tick) begin
      r_phase <= '0;
    end else if (i_enable) begin
      r_phase <= r_phase + PH_W'(1);
    end
  end

endmodule

// File: rtl/timer_countdown_param.sv
// rtl/timer_countdown_param.sv - countdown timer with hold, abort, reload mode and rate strobes
module timer_countdown_param
  import timer_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_start_timer,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_periodic,
  input  logic             i_hold,
  input  logic             i_abort,
  output logic [CNT_W-1:0] o_counter,
  output logic             o_expired,
  output logic             o_expired_pulse,
  output logic             o_one_hz_enable,
  output logic             o_two_hz_enable,
  output logic             o_busy
);

  state_t           r_state;
  logic [CNT_W-1:0] r_counter;
  logic [CNT_W-1:0] r_reload;
  logic             r_mode;
  logic             r_expired;
  logic             r_expired_pulse;
  logic             r_one_hz;
  logic             r_two_hz;
  logic             r_busy;

  logic w_clear;
  logic w_enable;
  logic w_half_tick;
  logic w_unit_tick;

  // The edge that leaves HOLD already counts, so a hold of N cycles delays ticks by exactly N.
  assign w_clear  = i_abort | i_start_timer;
  assign w_enable = r_busy & ~i_hold;

  timer_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (w_clear),
    .i_enable   (w_enable),
    .o_half_tick(w_half_tick),
    .o_unit_tick(w_unit_tick)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state         <= ST_IDLE;
      r_counter       <= '0;
      r_reload        <= '0;
      r_mode          <= MODE_ONESHOT;
      r_expired       <= 1'b0;
      r_expired_pulse <= 1'b0;
      r_one_hz        <= 1'b0;
      r_two_hz        <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_expired_pulse <= 1'b0;
      r_one_hz        <= 1'b0;
      r_two_hz        <= 1'b0;
      if (i_abort) begin
        r_state   <= ST_IDLE;
        r_counter <= '0;
        r_busy    <= 1'b0;
        r_expired <= 1'b0;
      end else if (i_start_timer) begin
        r_counter <= i_value;
        r_reload  <= i_value;
        r_mode    <= i_periodic;
        if (i_value != '0) begin
          r_state   <= ST_RUN;
          r_busy    <= 1'b1;
          r_expired <= 1'b0;
        end else begin
          r_state         <= ST_EXPIRED;
          r_busy          <= 1'b0;
          r_expired       <= 1'b1;
          r_expired_pulse <= 1'b1;
        end
      end else if (r_busy) begin
        if (i_hold) begin
          r_state <= ST_HOLD;
        end else begin
          r_state  <= ST_RUN;
          r_one_hz <= w_unit_tick;
          r_two_hz <= w_half_tick | w_unit_tick;
          if (w_unit_tick) begin
            if (r_counter == CNT_W'(1)) begin
              r_expired_pulse <= 1'b1;
              if (r_mode == MODE_PERIODIC) begin
                r_counter <= r_reload;
              end else begin
                r_counter <= '0;
                r_state   <= ST_EXPIRED;
                r_busy    <= 1'b0;
                r_expired <= 1'b1;
              end
            end else if (r_counter != '0) begin
              r_counter <= r_counter - CNT_W'(1);
            end
          end
        end
      end
    end
  end

  assign o_counter       = r_counter;
  assign o_expired       = r_expired;
  assign o_expired_pulse = r_expired_pulse;
  assign o_one_hz_enable = r_one_hz;
  assign o_two_hz_enable = r_two_hz;
  assign o_busy          = r_busy;

endmodule

// File: tb/tb_timer_countdown_param.sv
// tb/tb_timer_countdown_param.sv - directed vector bench for the countdown timer
module tb_timer_countdown_param;

  localparam int CLK_HZ = 10;
  localparam int CNT_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] value = '0;
  logic             periodic = 1'b0;
  logic             hold = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] counter;
  logic             expired;
  logic             expired_pulse;
  logic             one_hz;
  logic             two_hz;
  logic             busy;
  logic [8:0]       obs;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign obs = {counter, expired, expired_pulse, one_hz, two_hz, busy};

  timer_countdown_param #(
    .CLK_HZ(CLK_HZ),
    .CNT_W (CNT_W)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_start_timer  (start),
    .i_value        (value),
    .i_periodic     (periodic),
    .i_hold         (hold),
    .i_abort        (abort),
    .o_counter      (counter),
    .o_expired      (expired),
    .o_expired_pulse(expired_pulse),
    .o_one_hz_enable(one_hz),
    .o_two_hz_enable(two_hz),
    .o_busy         (busy)
  );

  typedef struct {
    string      name;
    logic       start;
    logic [3:0] value;
    logic       periodic;
    logic       hold;
    logic       abort;
    int         n;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic s, logic [3:0] v, logic p, logic h, logic a,
                              int n, logic [3:0] c, logic e, logic pl, logic o, logic t,
                              logic b);
    vec_t r;
    r.name     = nm;
    r.start    = s;
    r.value    = v;
    r.periodic = p;
    r.hold     = h;
    r.abort    = a;
    r.n        = n;
    r.exp      = {c, e, pl, o, t, b};
    return r;
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(string nm, logic [8:0] act, logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {cnt,exp,pls,1hz,2hz,busy}=%0d,%b want %0d,%b",
               nm, act[8:5], act[4:0], exp[8:5], exp[4:0]);
    end
  endtask

  initial begin
    //                  name             s  v  p  h  a   n  cnt e pl o t b
    vecs.push_back(mk("s1_load",        1, 3, 0, 0, 0,  1, 3, 0, 0, 0, 0, 1));
    vecs.push_back(mk("s1_e4",          0, 0, 0, 0, 0,  4, 3, 0, 0, 0, 0, 1));
    vecs.push_back(mk("s1_half",        0, 0, 0, 0, 0,  1, 3, 0, 0, 0, 1, 1));
    vecs.push_back(mk("s1_e9",          0, 0, 0, 0, 0,  4, 3, 0, 0, 0, 0, 1));
    vecs.push_back(mk("s1_tick10",      0, 0, 0, 0, 0,  1, 2, 0, 0, 1, 1, 1));
    vecs.push_back(mk("s1_tick20",      0, 0, 0, 0, 0, 10, 1, 0, 0, 1, 1, 1));
    vecs.push_back(mk("s1_term30",      0, 0, 0, 0, 0, 10, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk("s1_after",       0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("s1_stay_hold",   0, 0, 0, 1, 0, 20, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("s2_load",        1, 2, 1, 0, 0,  1, 2, 0, 0, 0, 0, 1));
    vecs.push_back(mk("s2_t10",         0, 0, 0, 0, 0, 10, 1, 0, 0, 1, 1, 1));
    vecs.push_back(mk("s2_t20_reload",  0, 0, 0, 0, 0, 10, 2, 0, 1, 1, 1, 1));
    vecs.push_back(mk("s2_e21",         0, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0, 1));
    vecs.push_back(mk("s2_t40_reload",  0, 0, 0, 0, 0, 19, 2, 0, 1, 1, 1, 1));
    vecs.push_back(mk("s2_t50",         0, 0, 0, 0, 0, 10, 1, 0, 0, 1, 1, 1));
    vecs.push_back(mk("s5_run",         0, 0, 0, 0, 0,  3, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk("s5_abort_start", 1, 7, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("s5_idle_hold",   0, 0, 0, 1, 0,  5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("s4_zero",        1, 0, 0, 0, 0,  1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("s4_after",       0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("s4_stay_hold",   0, 0, 0, 1, 0, 15, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("held_start",     1, 4, 0, 0, 0, 12, 4, 0, 0, 0, 0, 1));
    vecs.push_back(mk("held_e9",        0, 0, 0, 0, 0,  9, 4, 0, 0, 0, 0, 1));
    vecs.push_back(mk("held_tick",      0, 0, 0, 0, 0,  1, 3, 0, 0, 1, 1, 1));
    vecs.push_back(mk("restart_v1",     1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk("v1_term",        0, 0, 0, 0, 0, 10, 0, 1, 1, 1, 1, 0));
    vecs.push_back(mk("abort_expired",  0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0));

    step(2);
    check("reset_state", obs, 9'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      start    = vecs[i].start;
      value    = vecs[i].value;
      periodic = vecs[i].periodic;
      hold     = vecs[i].hold;
      abort    = vecs[i].abort;
      step(vecs[i].n);
      check(vecs[i].name, obs, vecs[i].exp);
    end
    start = 1'b0; value = '0; periodic = 1'b0; hold = 1'b0; abort = 1'b0;

    // Hold for 7 edges (5..11) pushes the first tick from edge 10 to 17.
    start = 1'b1; value = 4'd2;
    step(1);
    start = 1'b0;
    step(4);
    hold = 1'b1;
    for (int k = 5; k <= 11; k++) begin
      step(1);
      check($sformatf("hold_e%0d", k), obs, {4'd2, 5'b00001});
    end
    hold = 1'b0;
    step(1);
    check("hold_resume_half", obs, {4'd2, 5'b00011});
    step(4);
    check("hold_e16", obs, {4'd2, 5'b00001});
    step(1);
    check("hold_tick17", obs, {4'd1, 5'b00111});
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("hold_abort", obs, 9'd0);

    // Asynchronous reset in the middle of a value=5 run.
    start = 1'b1; value = 4'd5;
    step(1);
    start = 1'b0;
    step(15);
    check("rst_pre_e15", obs, {4'd4, 5'b00011});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_clear", obs, 9'd0);
    step(2);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(1);
      check($sformatf("rst_idle_%0d", k), obs, 9'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
